mdu_ctl: RTL and testbench
==========================

# mdu_ctl

Parametrised multiply/divide unit for the execute stage. It decodes the R-type `funct` field for the HI/LO instruction group: `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi`, `mflo`. It runs multiply/divide as a multi-cycle operation with a `busy` handshake and owns the HI/LO architectural registers. It sits beside the ALU; the hazard unit stalls on `busy`, and the datapath reads HI/LO through `rdata`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for `mult`/`multu`. Must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`. Must be ≥ 1.

- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: an instruction in E carries a valid `funct` this cycle.
- `funct` input 6: R-type funct field.
- `a` input WIDTH: rs operand.
- `b` input WIDTH: rt operand.
- `flush` input 1: kill the in-flight operation (exception/eret).
- `is_md` output 1: combinational; 1 when `funct` is one of the 8 HI/LO functs (0x10–0x13, 0x18–0x1B), independent of `start`.
- `busy` output 1: registered; a multi-cycle operation is in flight.
- `hi` output WIDTH: registered HI.
- `lo` output WIDTH: registered LO.
- `rdata` output WIDTH: combinational; `hi` when `funct`=0x10 (`mfhi`), `lo` when `funct`=0x12 (`mflo`), otherwise 0.

## Operation
- Funct map: 0x10 `mfhi`, 0x11 `mthi`, 0x12 `mflo`, 0x13 `mtlo`, 0x18 `mult`, 0x19 `multu`, 0x1A `div`, 0x1B `divu`. Any other funct has no effect on state.
- FSM states are IDLE and RUN.
  - IDLE → RUN on an accepted mult/div start. The cycle counter loads MUL_CYCLES or DIV_CYCLES.
  - In RUN the counter decrements each cycle. RUN → IDLE on the edge where the counter is 1; that edge also commits the pending HI/LO.
  - RUN → IDLE on `flush`. HI/LO are not changed.
- Accept rule: a `start` is accepted only when state is IDLE and `flush`=0.
  - A `start` while busy is ignored; stalling the pipeline is the hazard unit's job.
  - `flush` and `start` in the same cycle: no accept.
- At accept, the result is computed from `a`/`b` and held in pending registers, so later changes to `a`/`b` have no effect.
- `mult`: signed 2·WIDTH product. `multu`: unsigned product. `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
- `div`: signed division. `lo` = quotient truncated toward zero; `hi` = remainder, with the sign of the dividend.
- `divu`: unsigned division. `lo` = quotient, `hi` = remainder.
- Divide by zero (both `div` and `divu`): `lo` = all ones, `hi` = `a`.
- Signed overflow (`div` with `a` = most-negative, `b` = −1): `lo` = `a`, `hi` = 0.
- `mthi`/`mtlo` (accepted, IDLE): write `a` into `hi`/`lo` at the next edge. `busy` is not asserted.
- `mfhi`/`mflo` never change state. `rdata` reflects the registers as they are, including during RUN (old values). The hazard unit stalls mf* while `busy`.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, counter 0, pending registers 0. Reset overrides every other input, including mid-RUN: the operation is abandoned and HI/LO are zeroed.
- Multiply/divide with N = MUL_CYCLES or DIV_CYCLES, accepted in cycle 0:
  - `busy`=1 in cycles 1..N.
  - `busy`=0 and the new `hi`/`lo` are visible in cycle N+1.
  - A new `start` is acceptable in cycle N+1 (back-to-back).
- `mthi`/`mtlo` accepted in cycle 0: the new value is visible in cycle 1.
- `flush` in any RUN cycle k: `busy`=0 from cycle k+1; HI/LO keep their pre-op values.
- `flush` in the commit cycle N: flush wins and HI/LO are not updated.
- `is_md` and `rdata` have zero latency: they are purely combinational from `funct`, `hi`, `lo`.

## Test plan
- Reset, then `mult` with a=0xFFFFFFFE, b=3 (WIDTH=32, MUL_CYCLES=5) → `busy` high for cycles 1–5; in cycle 6 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. `multu` with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- `div` a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. `divu` a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7. `div` a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- `mthi` a=0x12345678, then `mflo` funct in the next cycle → `hi`=0x12345678 in cycle 1, `busy` never asserted; `rdata` = `lo` for `mflo` and = `hi` for `mfhi`.
- `mult` accepted, then `start`+`mtlo` in cycle 3 → ignored, `lo` is only the product at cycle 6. `flush` in cycle 3 of a second `mult` → `busy`=0 in cycle 4 and HI/LO unchanged.
- `reset` asserted in cycle 2 of a `div` → next cycle `busy`=0, `hi`=`lo`=0; a subsequent `divu` 100/7 completes normally with `lo`=14, `hi`=2.
- Sweep all 64 funct values with `start`=1 in IDLE → `is_md` is 1 only for the 8 listed codes; the other 56 change no state.

Source files
------------

// File: rtl/mdu_ctl.sv
// HI/LO multiply/divide unit: decodes the HI/LO funct group, computes the result at accept,
// holds it as pending for a fixed number of busy cycles, then commits it to HI/LO.
module mdu_ctl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             is_md,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic             busy_q;

    logic                      accept;
    logic                      op_md;
    logic [CW-1:0]             op_cycles;
    logic [WIDTH-1:0]          res_hi, res_lo;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          q_s, r_s, q_u, r_u;

    always_comb begin
        is_md = 1'b0;
        case (funct)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
            default:                        is_md = 1'b0;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (funct == F_MFHI)      rdata = hi_q;
        else if (funct == F_MFLO) rdata = lo_q;
    end

    // Arithmetic is evaluated on the live operands; only the accept edge captures it.
    always_comb begin
        prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        q_s = '1;
        r_s = a;
        q_u = '1;
        r_u = a;
        if (b != '0) begin
            q_u = a / b;
            r_u = a % b;
            if (a == MOST_NEG && b == '1) begin
                q_s = a;
                r_s = '0;
            end else begin
                q_s = $signed(a) / $signed(b);
                r_s = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        op_md     = 1'b0;
        op_cycles = '0;
        res_hi    = '0;
        res_lo    = '0;
        case (funct)
            F_MULT: begin
                op_md = 1'b1; op_cycles = CW'(MUL_CYCLES);
                res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0];
            end
            F_MULTU: begin
                op_md = 1'b1; op_cycles = CW'(MUL_CYCLES);
                res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0];
            end
            F_DIV: begin
                op_md = 1'b1; op_cycles = CW'(DIV_CYCLES);
                res_hi = r_s; res_lo = q_s;
            end
            F_DIVU: begin
                op_md = 1'b1; op_cycles = CW'(DIV_CYCLES);
                res_hi = r_u; res_lo = q_u;
            end
            default: begin
                op_md = 1'b0;
            end
        endcase
    end

    assign accept = start && !flush && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_md) begin
                        state_d = S_RUN;
                        cnt_d   = op_cycles;
                        phi_d   = res_hi;
                        plo_d   = res_lo;
                    end else if (funct == F_MTHI) begin
                        hi_d = a;
                    end else if (funct == F_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                // Flush takes priority even on the commit edge.
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            busy_q  <= (state_d == S_RUN);
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctl.sv
// Randomized scoreboard bench for mdu_ctl: the driver pushes the expected post-edge
// busy/HI/LO for every cycle, a monitor pops and compares after each rising edge.
module tb_mdu_ctl;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        is_md, busy;
    logic [31:0] hi, lo, rdata;

    mdu_ctl #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
        .flush(flush), .is_md(is_md), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;

    // Architectural model: committed HI/LO, pending result, remaining busy cycles.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ref_op = '0;
        case (f)
            6'h18: begin
                q = sx * sy;
                ref_op = q;
            end
            6'h19: begin
                p = {32'b0, x} * {32'b0, y};
                ref_op = p;
            end
            6'h1A: begin
                if (y == 0) ref_op = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_op = {32'h0, x};
                else begin
                    q = sx / sy;
                    r = sx - q * sy;
                    ref_op = {r[31:0], q[31:0]};
                end
            end
            6'h1B: begin
                if (y == 0) ref_op = {x, 32'hFFFF_FFFF};
                else begin
                    sx = longint'({32'b0, x});
                    sy = longint'({32'b0, y});
                    q = sx / sy;
                    r = sx % sy;
                    ref_op = {r[31:0], q[31:0]};
                end
            end
            default: ref_op = '0;
        endcase
    endfunction

    task automatic step(input logic r, input logic s, input logic [5:0] f,
                        input logic [31:0] aa, input logic [31:0] bb, input logic fl);
        logic        exp_md;
        logic [31:0] exp_rd;
        logic [63:0] res;
        exp_t        e;
        @(negedge clk);
        reset = r; start = s; funct = f; a = aa; b = bb; flush = fl;
        #1;
        exp_md = (f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B);
        exp_rd = (f == 6'h10) ? m_hi : (f == 6'h12) ? m_lo : 32'h0;
        check("is_md", {31'b0, is_md}, {31'b0, exp_md});
        if (!r) check("rdata", rdata, exp_rd);
        if (r) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0;
        end else if (m_rem > 0) begin
            if (fl) m_rem = 0;
            else if (m_rem == 1) begin
                m_hi = m_phi; m_lo = m_plo; m_rem = 0;
            end else m_rem--;
        end else if (s && !fl) begin
            case (f)
                6'h18, 6'h19: begin res = ref_op(f, aa, bb); m_phi = res[63:32]; m_plo = res[31:0]; m_rem = 5; end
                6'h1A, 6'h1B: begin res = ref_op(f, aa, bb); m_phi = res[63:32]; m_plo = res[31:0]; m_rem = 10; end
                6'h11: m_hi = aa;
                6'h13: m_lo = aa;
                default: ;
            endcase
        end
        e.busy = (m_rem > 0); e.hi = m_hi; e.lo = m_lo; e.cyc = cyc + 1;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, $urandom, $urandom, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp_cnt++;
            if (busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
                err_cnt++;
                $display("FAIL state cycle %0d: got busy=%b hi=%h lo=%h expected busy=%b hi=%h lo=%h",
                         e.cyc, busy, hi, lo, e.busy, e.hi, e.lo);
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: rnd_operand = 32'h0;
            1: rnd_operand = 32'hFFFF_FFFF;
            2: rnd_operand = 32'h8000_0000;
            3: rnd_operand = $urandom_range(0, 20);
            default: rnd_operand = $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0; flush = 1'b0;
        step(1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        settle();
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_hi", hi, 32'h0);

        step(1'b0, 1'b1, 6'h18, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(5); settle();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        step(1'b0, 1'b1, 6'h19, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(5); settle();
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        step(1'b0, 1'b1, 6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10); settle();
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
        step(1'b0, 1'b1, 6'h1B, 32'd7, 32'd0, 1'b0);
        idle(10); settle();
        check("divu0_hi", hi, 32'd7);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10); settle();
        check("divovf_hi", hi, 32'h0);
        check("divovf_lo", lo, 32'h8000_0000);

        step(1'b0, 1'b1, 6'h11, 32'h1234_5678, 32'h0, 1'b0);
        settle();
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'b0, busy}, 32'h0);
        step(1'b0, 1'b0, 6'h12, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 6'h10, 32'h0, 32'h0, 1'b0);

        step(1'b0, 1'b1, 6'h18, 32'h0000_1234, 32'h0000_0100, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 6'h13, 32'hDEAD_BEEF, 32'h0, 1'b0);
        idle(2); settle();
        check("mtlo_ignored_lo", lo, 32'h0012_3400);
        step(1'b0, 1'b1, 6'h18, 32'd5, 32'd5, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
        settle();
        check("flush_busy", {31'b0, busy}, 32'h0);
        check("flush_lo", lo, 32'h0012_3400);
        step(1'b0, 1'b1, 6'h19, 32'd9, 32'd9, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
        settle();
        check("flush_commit_lo", lo, 32'h0012_3400);

        step(1'b0, 1'b1, 6'h1A, 32'd50, 32'd3, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        settle();
        check("rst_run_busy", {31'b0, busy}, 32'h0);
        check("rst_run_hi", hi, 32'h0);
        step(1'b0, 1'b1, 6'h1B, 32'd100, 32'd7, 1'b0);
        idle(10); settle();
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        for (int f = 0; f < 64; f++) begin
            step(1'b0, 1'b1, 6'(f), $urandom, $urandom_range(1, 1000), 1'b0);
            idle(m_rem);
        end

        for (int i = 0; i < 1500; i++) begin
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (6'h10 | 6'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 6'h08 : 6'h00));
            ra = rnd_operand();
            rb = rnd_operand();
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rf, ra, rb, $urandom_range(0, 15) == 0);
        end

        idle(2);
        settle();
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
